// File: rtl/store_tracer_pkg.sv
// rtl/store_tracer_pkg.sv - shared status encoding and trace entry width
package store_tracer_pkg;

  typedef enum logic [1:0] {
    RUN  = 2'b00,
    PASS = 2'b01,
    FAIL = 2'b10
  } status_t;

  localparam int TRACE_W = 64;

endpackage

// File: rtl/store_tracer_if.sv
// rtl/store_tracer_if.sv - processor store bus plus trace output stream
interface store_tracer_if;

  logic        MemWrite;
  logic [31:0] DataAdr;
  logic [31:0] WriteData;
  logic        trace_valid;
  logic        trace_ready;
  logic [31:0] trace_addr;
  logic [31:0] trace_data;

  modport slave (
    input  MemWrite,
    input  DataAdr,
    input  WriteData,
    input  trace_ready,
    output trace_valid,
    output trace_addr,
    output trace_data
  );

  modport master (
    output MemWrite,
    output DataAdr,
    output WriteData,
    output trace_ready,
    input  trace_valid,
    input  trace_addr,
    input  trace_data
  );

endinterface

// File: rtl/trace_fifo.sv
// rtl/trace_fifo.sv - generic DEPTH x WIDTH synchronous FIFO with registered head
module trace_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic             o_full,
  output logic             o_empty,
  output logic [WIDTH-1:0] o_head
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [CW-1:0]    r_count;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_head  = r_mem[r_rptr];

  // A full FIFO still accepts a push when the head leaves on the same edge.
  assign w_pop  = i_pop && !o_empty;
  assign w_push = i_push && (!o_full || w_pop);

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= i_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + AW'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/store_tracer.sv
// rtl/store_tracer.sv - traces processor stores into a FIFO and judges pass/fail
module store_tracer
  import store_tracer_pkg::*;
#(
  parameter int          DEPTH        = 8,
  parameter logic [31:0] PASS_ADDR    = 32'd100,
  parameter logic [31:0] PASS_DATA    = 32'd7,
  parameter logic [31:0] SCRATCH_ADDR = 32'd96
) (
  input  logic                 clk,
  input  logic                 reset,
  store_tracer_if.slave        bus,
  output logic [7:0]           drop_count,
  output logic [1:0]           status,
  output logic                 done
);

  status_t            r_status;
  logic               r_done;
  logic [7:0]         r_drop;
  logic               w_store;
  logic               w_pop;
  logic               w_full;
  logic               w_empty;
  logic               w_push;
  logic               w_drop;
  logic [TRACE_W-1:0] w_head;

  assign w_store = bus.MemWrite && (r_status == RUN);
  assign w_pop   = !w_empty && bus.trace_ready;
  assign w_push  = w_store && (!w_full || w_pop);
  assign w_drop  = w_store && !w_push;

  trace_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (TRACE_W)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push),
    .i_data  ({bus.DataAdr, bus.WriteData}),
    .i_pop   (w_pop),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_head  (w_head)
  );

  assign bus.trace_valid = !w_empty;
  assign bus.trace_addr  = w_head[TRACE_W-1:32];
  assign bus.trace_data  = w_head[31:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_drop <= '0;
    end else if (w_drop && (r_drop != 8'hFF)) begin
      r_drop <= r_drop + 8'd1;
    end
  end

  // Only scratch stores and the single correct pass store keep the program running.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_status <= RUN;
      r_done   <= 1'b0;
    end else begin
      case (r_status)
        RUN: begin
          if (w_store) begin
            if (bus.DataAdr == PASS_ADDR) begin
              r_status <= (bus.WriteData == PASS_DATA) ? PASS : FAIL;
              r_done   <= 1'b1;
            end else if (bus.DataAdr != SCRATCH_ADDR) begin
              r_status <= FAIL;
              r_done   <= 1'b1;
            end
          end
        end
        PASS:    r_status <= PASS;
        FAIL:    r_status <= FAIL;
        default: begin
          r_status <= FAIL;
          r_done   <= 1'b1;
        end
      endcase
    end
  end

  assign drop_count = r_drop;
  assign status     = r_status;
  assign done       = r_done;

endmodule

// File: tb/tb_store_tracer.sv
// tb/tb_store_tracer.sv - vector table, directed corners and random run against a queue model
module tb_store_tracer;

  localparam int          DEPTH   = 8;
  localparam logic [31:0] P_ADDR  = 32'd100;
  localparam logic [31:0] P_DATA  = 32'd7;
  localparam logic [31:0] S_ADDR  = 32'd96;

  logic       clk;
  logic       reset;
  logic [7:0] drop_count;
  logic [1:0] status;
  logic       done;

  store_tracer_if bus ();

  store_tracer #(
    .DEPTH        (DEPTH),
    .PASS_ADDR    (P_ADDR),
    .PASS_DATA    (P_DATA),
    .SCRATCH_ADDR (S_ADDR)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus.slave),
    .drop_count (drop_count),
    .status     (status),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model: queue of {addr,data}, saturating drop total, status 0=run 1=pass 2=fail
  logic [63:0] m_q[$];
  int          m_drop;
  int          m_st;

  typedef struct {
    bit          rst;
    bit          mw;
    logic [31:0] a;
    logic [31:0] d;
    bit          rdy;
    bit          ev;
    logic [31:0] ea;
    logic [31:0] ed;
    int          edrop;
    int          est;
  } vec_t;

  vec_t tv[8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_clear();
    m_q.delete();
    m_drop = 0;
    m_st   = 0;
  endtask

  task automatic do_reset();
    bus.MemWrite    = 1'b0;
    bus.DataAdr     = '0;
    bus.WriteData   = '0;
    bus.trace_ready = 1'b0;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_clear();
  endtask

  task automatic chk_model();
    chk("valid", 64'(bus.trace_valid), 64'(m_q.size() > 0));
    if (m_q.size() > 0) begin
      chk("head", {bus.trace_addr, bus.trace_data}, m_q[0]);
    end
    chk("drop", 64'(drop_count), 64'(m_drop));
    chk("status", 64'(status), 64'(m_st));
    chk("done", 64'(done), 64'(m_st != 0));
  endtask

  task automatic cycle(input bit mw, input logic [31:0] a, input logic [31:0] d, input bit rdy);
    bit pop;
    bit store;
    bit push;
    bus.MemWrite    = mw;
    bus.DataAdr     = a;
    bus.WriteData   = d;
    bus.trace_ready = rdy;
    pop   = (m_q.size() > 0) && rdy;
    store = mw && (m_st == 0);
    push  = store && ((m_q.size() < DEPTH) || pop);
    @(posedge clk);
    #1;
    if (pop) void'(m_q.pop_front());
    if (push) m_q.push_back({a, d});
    if (store && !push && m_drop < 255) m_drop++;
    if (store) begin
      if (a == P_ADDR) m_st = (d == P_DATA) ? 1 : 2;
      else if (a != S_ADDR) m_st = 2;
    end
    bus.MemWrite = 1'b0;
    chk_model();
  endtask

  initial begin
    bus.MemWrite    = 1'b0;
    bus.DataAdr     = '0;
    bus.WriteData   = '0;
    bus.trace_ready = 1'b0;
    reset = 1'b1;
    model_clear();
    @(posedge clk);
    #1;
    chk("rst_valid", 64'(bus.trace_valid), 64'd0);
    chk("rst_drop", 64'(drop_count), 64'd0);
    chk("rst_status", 64'(status), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    reset = 1'b0;

    // Pass path, post-pass ignore, fail path, wrong data at the pass address
    tv[0] = '{1'b1, 1'b1, 32'd96,  32'd3, 1'b1, 1'b1, 32'd96,  32'd3, 0, 0};
    tv[1] = '{1'b0, 1'b1, 32'd100, 32'd7, 1'b1, 1'b1, 32'd100, 32'd7, 0, 1};
    tv[2] = '{1'b0, 1'b0, 32'd0,   32'd0, 1'b1, 1'b0, 32'd0,   32'd0, 0, 1};
    tv[3] = '{1'b0, 1'b1, 32'd96,  32'd5, 1'b1, 1'b0, 32'd0,   32'd0, 0, 1};
    tv[4] = '{1'b1, 1'b1, 32'd200, 32'd1, 1'b0, 1'b1, 32'd200, 32'd1, 0, 2};
    tv[5] = '{1'b0, 1'b1, 32'd100, 32'd7, 1'b0, 1'b1, 32'd200, 32'd1, 0, 2};
    tv[6] = '{1'b0, 1'b0, 32'd0,   32'd0, 1'b1, 1'b0, 32'd0,   32'd0, 0, 2};
    tv[7] = '{1'b1, 1'b1, 32'd100, 32'd8, 1'b1, 1'b1, 32'd100, 32'd8, 0, 2};
    for (int i = 0; i < 8; i++) begin
      if (tv[i].rst) do_reset();
      cycle(tv[i].mw, tv[i].a, tv[i].d, tv[i].rdy);
      chk($sformatf("tv%0d_valid", i), 64'(bus.trace_valid), 64'(tv[i].ev));
      if (tv[i].ev) chk($sformatf("tv%0d_head", i), {bus.trace_addr, bus.trace_data}, {tv[i].ea, tv[i].ed});
      chk($sformatf("tv%0d_drop", i), 64'(drop_count), 64'(tv[i].edrop));
      chk($sformatf("tv%0d_status", i), 64'(status), 64'(tv[i].est));
      chk($sformatf("tv%0d_done", i), 64'(done), 64'(tv[i].est != 0));
    end

    // Overfill, then a push+pop while full, then drain
    do_reset();
    for (int i = 0; i < 10; i++) cycle(1'b1, S_ADDR, 32'(i), 1'b0);
    chk("fill_drop", 64'(drop_count), 64'd2);
    cycle(1'b1, S_ADDR, 32'd50, 1'b1);
    chk("full_pushpop_drop", 64'(drop_count), 64'd2);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("drain%0d_valid", i), 64'(bus.trace_valid), 64'd1);
      chk($sformatf("drain%0d_data", i), 64'(bus.trace_data), (i < 7) ? 64'(i + 1) : 64'd50);
      cycle(1'b0, '0, '0, 1'b1);
    end
    chk("drain_empty", 64'(bus.trace_valid), 64'd0);

    // Asynchronous reset with five entries queued after a pass
    for (int i = 0; i < 4; i++) cycle(1'b1, S_ADDR, 32'(20 + i), 1'b0);
    cycle(1'b1, P_ADDR, P_DATA, 1'b0);
    chk("pre_rst_status", 64'(status), 64'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("async_valid", 64'(bus.trace_valid), 64'd0);
    chk("async_drop", 64'(drop_count), 64'd0);
    chk("async_status", 64'(status), 64'd0);
    chk("async_done", 64'(done), 64'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_clear();
    cycle(1'b1, S_ADDR, 32'hAB, 1'b1);
    chk("post_rst_head", {bus.trace_addr, bus.trace_data}, {S_ADDR, 32'hAB});

    // Drop counter saturation
    do_reset();
    for (int i = 0; i < 300; i++) cycle(1'b1, S_ADDR, 32'(i), 1'b0);
    chk("drop_sat", 64'(drop_count), 64'd255);

    // Random episodes with varying consumer back-pressure
    for (int ep = 0; ep < 4; ep++) begin
      do_reset();
      for (int c = 0; c < 250; c++) begin
        logic [31:0] a;
        logic [31:0] d;
        int r;
        r = $urandom_range(0, 99);
        a = (r < 97) ? S_ADDR : (r < 99) ? P_ADDR : 32'($urandom);
        d = (a == P_ADDR && $urandom_range(0, 1) == 1) ? P_DATA : 32'($urandom);
        cycle(1'($urandom_range(0, 1)), a, d, ($urandom_range(0, 9) < ep * 3 + 1));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/store_tracer.md
STORE_TRACER -- requirements
Module: store_tracer

Interface
REQ-001 Parameter DEPTH, 8, trace FIFO entries; power of two, 2 to 64.
REQ-002 Parameter PASS_ADDR, 32'd100, store address that ends the program successfully.
REQ-003 Parameter PASS_DATA, 32'd7, store data required at PASS_ADDR.
REQ-004 Parameter SCRATCH_ADDR, 32'd96, address of the only other store the program is allowed to make.
REQ-005 clk  in  1  single clock; all state updates on its rising edge.
REQ-006 reset  in  1  asynchronous, active-high reset.
REQ-007 MemWrite  in  1  processor store strobe; one store per cycle in which it is high.
REQ-008 DataAdr  in  32  processor store address.
REQ-009 WriteData  in  32  processor store data.
REQ-010 trace_valid  out  1  FIFO head entry is available.
REQ-011 trace_ready  in  1  consumer accepts the head entry.
REQ-012 trace_addr  out  32  head entry address.
REQ-013 trace_data  out  32  head entry data.
REQ-014 drop_count  out  8  stores lost because the FIFO was full; saturates at 255.
REQ-015 status  out  2  RUN, PASS or FAIL.
REQ-016 done  out  1  high when status is PASS or FAIL.

Function
REQ-017 A store is any rising edge with MemWrite=1 while status=RUN.
REQ-018 Each store shall push {DataAdr, WriteData} into the FIFO if it is not full, or if it is full and a pop occurs on the same edge.
REQ-019 A pop shall occur on an edge with trace_valid=1 and trace_ready=1.
REQ-020 trace_addr and trace_data shall be stable while trace_valid=1 and no pop has occurred; with trace_valid=0 their values are don't-care.
REQ-021 Push-to-valid latency shall be one cycle, with no combinational bypass from MemWrite to trace_valid.
REQ-022 Entries shall leave the FIFO in push order; read and write pointers wrap modulo DEPTH.
REQ-023 Push and pop on the same edge at any occupancy shall leave occupancy unchanged.
REQ-024 A store that is refused under REQ-018 shall increment drop_count by one, holding at 255.
REQ-025 The status FSM has states RUN, PASS and FAIL; the reset state is RUN.
REQ-026 RUN->PASS on a store with DataAdr==PASS_ADDR and WriteData==PASS_DATA.
REQ-027 RUN->FAIL on a store whose DataAdr is neither SCRATCH_ADDR nor PASS_ADDR, or whose DataAdr is PASS_ADDR with WriteData!=PASS_DATA.
REQ-028 PASS and FAIL shall be sticky until reset.
REQ-029 The store that causes the transition shall itself be pushed, or counted as dropped, under REQ-018/REQ-024.
REQ-030 With status!=RUN, MemWrite shall be ignored: no push and no drop count; the FIFO continues to drain.
REQ-031 status and done shall change on the edge that samples the triggering store, and not combinationally.

Reset
REQ-032 Asserting reset shall immediately clear the FIFO pointers and occupancy and force trace_valid=0, drop_count=0, status=RUN and done=0.
REQ-033 FIFO storage array contents need no reset.
REQ-034 Reset mid-drain shall discard every queued entry; no stale entry shall appear after reset deasserts.

Structure
REQ-035 Package store_tracer_pkg shall hold the status_t enum (RUN=2'b00, PASS=2'b01, FAIL=2'b10) and the TRACE_W=64 entry width constant.
REQ-036 Sub-module trace_fifo shall provide a generic DEPTH x TRACE_W synchronous FIFO with push, pop, full, empty and head outputs; store_tracer shall add the FSM, accept logic and drop counter.
REQ-037 store_tracer shall connect directly to the processor top's DataAdr, WriteData and MemWrite outputs with no glue logic.

Verification
REQ-038 Store 96/3, then store 100/7, with trace_ready=1 -> two entries out in order (96,3),(100,7); status=PASS and done=1 from the edge of the second store.
REQ-039 Store 200/1 -> status=FAIL; a following store 100/7 is not pushed and status stays FAIL.
REQ-040 Hold trace_ready=0 and issue 10 stores to address 96 with DEPTH=8 -> 8 entries held, drop_count=2; then drain -> data order preserved and trace_valid=0 after 8 pops.
REQ-041 FIFO full with push and pop on the same edge -> occupancy stays 8 and drop_count is unchanged.
REQ-042 Assert reset with 5 entries queued and status=PASS -> trace_valid=0, drop_count=0 and status=RUN without waiting for a clock edge; the next store is the first entry out.
REQ-043 Issue 300 drops -> drop_count saturates at 255.
